// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: instruction field
// positions, ALU opcodes, FSM state encoding and an instruction decoder.
package alu_seq_pkg;

  localparam int unsigned INSTR_W   = 24;

  // Instruction field bit positions
  localparam int unsigned WRITE_BIT = 23;
  localparam int unsigned FUNC_MSB  = 22;
  localparam int unsigned FUNC_LSB  = 20;
  localparam int unsigned RD_MSB    = 19;
  localparam int unsigned RD_LSB    = 16;
  localparam int unsigned A1_MSB    = 15;
  localparam int unsigned A1_LSB    = 12;
  localparam int unsigned A2_MSB    = 11;
  localparam int unsigned A2_LSB    = 8;
  localparam int unsigned MEM_MSB   = 7;
  localparam int unsigned MEM_LSB   = 0;

  // ALU opcodes
  localparam logic [2:0] FUNC_ADD  = 3'd0;
  localparam logic [2:0] FUNC_SUB  = 3'd1;
  localparam logic [2:0] FUNC_AND  = 3'd2;
  localparam logic [2:0] FUNC_OR   = 3'd3;
  localparam logic [2:0] FUNC_XOR  = 3'd4;
  localparam logic [2:0] FUNC_NOTA = 3'd5;
  localparam logic [2:0] FUNC_NOTB = 3'd6;
  localparam logic [2:0] FUNC_INCA = 3'd7;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_STALL = 2'd2,
    ST_ISSUE = 2'd3
  } seq_state_e;

  // Decoded instruction
  typedef struct packed {
    logic       write;
    logic [2:0] func;
    logic [3:0] rd;
    logic [3:0] addr1;
    logic [3:0] addr2;
    logic [7:0] memaddr;
  } instr_t;

  // Split a raw instruction word into its fields
  function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
    instr_t f;
    f.write   = raw[WRITE_BIT];
    f.func    = raw[FUNC_MSB:FUNC_LSB];
    f.rd      = raw[RD_MSB:RD_LSB];
    f.addr1   = raw[A1_MSB:A1_LSB];
    f.addr2   = raw[A2_MSB:A2_LSB];
    f.memaddr = raw[MEM_MSB:MEM_LSB];
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Instruction queue: DEPTH entries of WIDTH bits, power-of-two depth so the
// pointers wrap naturally, registered occupancy count, no write-to-read bypass.
module alu_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Qualify requests against occupancy and compute next pointers/count
  always_comb begin
    do_push_s = push && (count_q < DEPTH_C);
    do_pop_s  = pop && (count_q != {CW{1'b0}});
    if (do_push_s) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only meaningful between pointers
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_instr_sequencer.sv
// ALU instruction sequencer: queues incoming instructions, checks the head
// against the previously issued instruction for a read-after-write hazard,
// inserts bubble cycles on a hazard and presents each instruction to the ALU
// for a fixed number of cycles.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int RAW_STALL   = 2
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_instr,
  input  logic        pause,
  output logic [3:0]  addr1,
  output logic [3:0]  addr2,
  output logic [3:0]  rd,
  output logic [2:0]  func,
  output logic [7:0]  memaddr,
  output logic        write,
  output logic        issue_valid,
  output logic [4:0]  count,
  output logic [7:0]  stall_cnt
);

  // Last cycle index of the hold and stall phases (timer counts from 0)
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] STALL_LAST = 8'(RAW_STALL - 1);
  localparam logic [4:0] DEPTH_C    = 5'(DEPTH);

  logic        fifo_push_s;
  logic        fifo_pop_s;
  logic [23:0] head_raw_s;
  instr_t      head_s;
  logic [4:0]  count_s;
  logic        queue_nonempty_s;
  logic        hazard_s;
  logic        load_s;

  seq_state_e  state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic [3:0]  addr1_q, addr1_d;
  logic [3:0]  addr2_q, addr2_d;
  logic [3:0]  rd_q, rd_d;
  logic [2:0]  func_q, func_d;
  logic [7:0]  memaddr_q, memaddr_d;
  logic        write_q, write_d;
  logic        issue_valid_q, issue_valid_d;
  logic        last_write_q, last_write_d;
  logic [3:0]  last_rd_q, last_rd_d;

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W),
    .CW    (5)
  ) u_fifo (
    .clk   (clk1),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .wdata (in_instr),
    .rdata (head_raw_s),
    .count (count_s)
  );

  // Upstream handshake and head-of-queue hazard detection
  always_comb begin
    in_ready         = (count_s < DEPTH_C);
    fifo_push_s      = in_valid && in_ready;
    queue_nonempty_s = (count_s != 5'd0);
    head_s           = decode_instr(head_raw_s);
    hazard_s         = last_write_q &&
                       ((head_s.addr1 == last_rd_q) || (head_s.addr2 == last_rd_q));
  end

  // Next-state logic: phase sequencing, stall counting, output loading
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    stall_cnt_d   = stall_cnt_q;
    addr1_d       = addr1_q;
    addr2_d       = addr2_q;
    rd_d          = rd_q;
    func_d        = func_q;
    memaddr_d     = memaddr_q;
    write_d       = write_q;
    issue_valid_d = issue_valid_q;
    last_write_d  = last_write_q;
    last_rd_d     = last_rd_q;
    load_s        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (queue_nonempty_s && !pause) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (hazard_s) begin
          state_d = ST_STALL;
          timer_d = 8'd0;
          if (stall_cnt_q != 8'd255) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
          end else begin
            stall_cnt_d = stall_cnt_q;
          end
        end else begin
          load_s = 1'b1;
        end
      end
      ST_STALL: begin
        if (timer_q == STALL_LAST) begin
          load_s = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_ISSUE: begin
        if (timer_q == HOLD_LAST) begin
          issue_valid_d = 1'b0;
          write_d       = 1'b0;
          timer_d       = 8'd0;
          if (queue_nonempty_s && !pause) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pop the head and present it; it becomes the hazard reference
    if (load_s) begin
      state_d       = ST_ISSUE;
      timer_d       = 8'd0;
      addr1_d       = head_s.addr1;
      addr2_d       = head_s.addr2;
      rd_d          = head_s.rd;
      func_d        = head_s.func;
      memaddr_d     = head_s.memaddr;
      write_d       = head_s.write;
      issue_valid_d = 1'b1;
      last_write_d  = head_s.write;
      last_rd_d     = head_s.rd;
    end else begin
      last_write_d  = last_write_q;
    end
  end

  assign fifo_pop_s = load_s;

  // Sequencer state and registered ALU-side outputs
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= 8'd0;
      stall_cnt_q   <= 8'd0;
      addr1_q       <= 4'd0;
      addr2_q       <= 4'd0;
      rd_q          <= 4'd0;
      func_q        <= 3'd0;
      memaddr_q     <= 8'd0;
      write_q       <= 1'b0;
      issue_valid_q <= 1'b0;
      last_write_q  <= 1'b0;
      last_rd_q     <= 4'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stall_cnt_q   <= stall_cnt_d;
      addr1_q       <= addr1_d;
      addr2_q       <= addr2_d;
      rd_q          <= rd_d;
      func_q        <= func_d;
      memaddr_q     <= memaddr_d;
      write_q       <= write_d;
      issue_valid_q <= issue_valid_d;
      last_write_q  <= last_write_d;
      last_rd_q     <= last_rd_d;
    end
  end

  assign addr1       = addr1_q;
  assign addr2       = addr2_q;
  assign rd          = rd_q;
  assign func        = func_q;
  assign memaddr     = memaddr_q;
  assign write       = write_q;
  assign issue_valid = issue_valid_q;
  assign count       = count_s;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: doc/alu_instr_sequencer.md
ALU_INSTR_SEQUENCER -- requirements
Module: alu_instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, instruction queue depth (power of 2, 2..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, cycles each issued instruction is held on the ALU-side outputs.
REQ-003 SHALL have parameter RAW_STALL, default 2, bubble cycles inserted on a read-after-write hazard.
REQ-004 SHALL have the following ports: clk1 input 1, the single clock, rising-edge.
REQ-005 rst input 1, synchronous reset, active-high.
REQ-006 in_valid input 1, upstream instruction valid.
REQ-007 in_ready output 1, queue can accept.
REQ-008 in_instr input 24, {write[23], func[22:20], rd[19:16], addr1[15:12], addr2[11:8], memaddr[7:0]}.
REQ-009 pause input 1, high blocks the start of a new issue.
REQ-010 addr1, addr2, rd output 4 each, ALU register addresses.
REQ-011 func output 3, ALU opcode (0 ADD … 7 INC A).
REQ-012 memaddr output 8, ALU result memory address.
REQ-013 write output 1, ALU writeback enable.
REQ-014 issue_valid output 1, high while an instruction is presented.
REQ-015 count output 5, queue occupancy.
REQ-016 stall_cnt output 8, saturating count of RAW stall events.

Function
REQ-017 Push when in_valid && in_ready; in_ready = (count < DEPTH), derived from registered count; push when full is impossible by construction.
REQ-018 Entry visible to FSM the cycle after push; no bypass.
REQ-019 FSM states IDLE, CHECK, STALL, ISSUE.
REQ-020 IDLE -> CHECK when count>0 and pause=0; otherwise remain IDLE.
REQ-021 CHECK: hazard if last issued write=1 and head addr1 or addr2 equals last issued rd; hazard -> STALL, else pop head, load output registers, -> ISSUE.
REQ-022 STALL lasts exactly RAW_STALL cycles, increments stall_cnt once (saturate at 255), then pops, loads outputs, -> ISSUE (hazard cleared).
REQ-023 ISSUE: issue_valid=1 and outputs stable for exactly HOLD_CYCLES cycles; write output equals instruction bit 23 for all of them.
REQ-024 After ISSUE: -> CHECK if count>0 and pause=0, else IDLE; outputs keep last fields, write=0, issue_valid=0.
REQ-025 Latency: idle queue, no hazard, pause=0: accept at cycle N -> issue_valid high at N+3.
REQ-026 Simultaneous push and pop in one cycle: count unchanged, both take effect.
REQ-027 Read/write pointers wrap modulo DEPTH.
REQ-028 pause asserted during ISSUE or STALL does not abort them; takes effect at the next decision point.
REQ-029 Hazard tracking covers only the immediately preceding issued instruction.

Reset
REQ-030 rst=1 at a clk1 edge: state IDLE, queue empty, count=0, in_ready=1 the following cycle, issue_valid=0, write=0, addr1/addr2/rd/func/memaddr=0, stall_cnt=0, hazard history cleared.
REQ-031 Reset mid-ISSUE or mid-STALL discards in-flight and queued instructions; nothing is re-issued.

Structure
REQ-032 Package alu_seq_pkg SHALL hold the instruction field bit positions, the FSM state enum, and func opcode constants (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOTA=5, NOTB=6, INCA=7).
REQ-033 Queue SHALL be a sub-module alu_seq_fifo (DEPTH x 24, synchronous reset, count output); FSM and hazard logic in the top.

Verification
REQ-034 Push {1,0,10,3,5,225} into an idle queue -> issue_valid 3 cycles later for 2 cycles; addr1=3, addr2=5, rd=10, func=0, memaddr=225, write=1.
REQ-035 ADD rd=10 followed by XOR addr1=10, addr2=5, rd=15 -> 2 bubble cycles between issues, stall_cnt=1; same XOR after a write=0 instruction -> no bubble.
REQ-036 pause=1, push 8 instructions -> count=8, in_ready=0, 9th in_valid not accepted; release pause -> 8 issues in push order, 2 cycles each.
REQ-037 Push 20 instructions at 1/cycle with pause=0 -> pointers wrap, all 20 issued in order, none lost or duplicated.
REQ-038 rst asserted in the 2nd ISSUE cycle with 3 queued -> next cycle issue_valid=0, write=0, count=0, no further issues.
